// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the CPU memory-port arbiter.
// Requester IDs double as bit positions in the one-hot grant vector.
package cpu_mem_pkg;

    localparam int DEF_ADDR_W = 11;
    localparam int DEF_DATA_W = 32;

    localparam int N_REQ  = 3;
    localparam int REQ_IF = 0;
    localparam int REQ_LD = 1;
    localparam int REQ_ST = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } arb_state_t;

    typedef logic [1:0] req_id_t;

    function automatic req_id_t grant_to_id(input logic [N_REQ-1:0] grant);
        if (grant[REQ_ST]) begin
            return req_id_t'(REQ_ST);
        end else if (grant[REQ_LD]) begin
            return req_id_t'(REQ_LD);
        end
        return req_id_t'(REQ_IF);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and the shared SRAM port.
// slave is the arbiter's view; master is the CPU/memory side.
interface mem_port_arbiter_if
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_gnt;
    logic              ld_rvalid;
    logic [DATA_W-1:0] ld_rdata;

    logic              st_req;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_wdata;
    logic              st_gnt;
    logic              st_done;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_gnt, if_rvalid, if_rdata,
        input  ld_req, ld_addr,
        output ld_gnt, ld_rvalid, ld_rdata,
        input  st_req, st_addr, st_wdata,
        output st_gnt, st_done,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr, if_flush,
        input  if_gnt, if_rvalid, if_rdata,
        output ld_req, ld_addr,
        input  ld_gnt, ld_rvalid, ld_rdata,
        output st_req, st_addr, st_wdata,
        input  st_gnt, st_done,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_select.sv
// Fixed-priority requester select (st > ld > if) with fetch starvation promotion.
// Grant is combinational and only meaningful while the arbiter is idle.
module mem_arb_select
    import cpu_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             idle,
    input  logic             if_req,
    input  logic             if_flush,
    input  logic             ld_req,
    input  logic             st_req,
    output logic [N_REQ-1:0] grant
);

    localparam int CNT_W = $clog2(STARVE_MAX + 2);

    logic [CNT_W-1:0] starve_reg;
    logic [CNT_W-1:0] starve_next;
    logic             if_ok;
    logic             starved;

    always_comb begin
        grant   = '0;
        if_ok   = if_req && !if_flush;
        starved = (starve_reg == CNT_W'(STARVE_MAX));
        if (idle) begin
            // A flush-blocked fetch cannot use its promotion; ld/st arbitrate normally.
            if (if_ok && starved) begin
                grant[REQ_IF] = 1'b1;
            end else if (st_req) begin
                grant[REQ_ST] = 1'b1;
            end else if (ld_req) begin
                grant[REQ_LD] = 1'b1;
            end else if (if_ok) begin
                grant[REQ_IF] = 1'b1;
            end
        end
    end

    always_comb begin
        starve_next = starve_reg;
        if (idle) begin
            if (grant[REQ_IF]) begin
                starve_next = '0;
            end else if (if_req && !starved) begin
                starve_next = starve_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_reg <= '0;
        end else begin
            starve_reg <= starve_next;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between fetch, load and store requesters:
// one access at a time, IDLE -> ACCESS (-> WAIT for reads) -> IDLE.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);

    arb_state_t        state_reg, state_next;
    req_id_t           owner_reg, owner_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [2:0]        wcnt_reg, wcnt_next;
    logic              kill_reg, kill_next;
    logic              if_rvalid_reg, if_rvalid_next;
    logic              ld_rvalid_reg, ld_rvalid_next;
    logic              st_done_reg, st_done_next;
    logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
    logic [DATA_W-1:0] ld_rdata_reg, ld_rdata_next;

    logic [N_REQ-1:0]  grant;
    logic              idle;
    logic              in_access;
    logic              owner_st;
    logic              wait_last;
    logic              flush_hit;

    // Grants are held off while reset is asserted so every output reads 0.
    assign idle      = (state_reg == IDLE) && !reset;
    assign in_access = (state_reg == ACCESS);
    assign owner_st  = (owner_reg == req_id_t'(REQ_ST));
    assign wait_last = (wcnt_reg == 3'(RD_LAT - 1));
    assign flush_hit = bus.if_flush && (state_reg != IDLE)
                       && (owner_reg == req_id_t'(REQ_IF));

    mem_arb_select #(
        .STARVE_MAX (STARVE_MAX)
    ) u_sel (
        .clk      (clk),
        .reset    (reset),
        .idle     (idle),
        .if_req   (bus.if_req),
        .if_flush (bus.if_flush),
        .ld_req   (bus.ld_req),
        .st_req   (bus.st_req),
        .grant    (grant)
    );

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        wcnt_next      = wcnt_reg;
        kill_next      = kill_reg;
        if_rvalid_next = 1'b0;
        ld_rvalid_next = 1'b0;
        st_done_next   = 1'b0;
        if_rdata_next  = if_rdata_reg;
        ld_rdata_next  = ld_rdata_reg;

        case (state_reg)
            IDLE: begin
                kill_next = 1'b0;
                if (|grant) begin
                    state_next = ACCESS;
                    owner_next = grant_to_id(grant);
                    wcnt_next  = '0;
                    wdata_next = grant[REQ_ST] ? bus.st_wdata : '0;
                    if (grant[REQ_ST]) begin
                        addr_next = bus.st_addr;
                    end else if (grant[REQ_LD]) begin
                        addr_next = bus.ld_addr;
                    end else begin
                        addr_next = bus.if_addr;
                    end
                end
            end
            ACCESS: begin
                kill_next = kill_reg || flush_hit;
                if (owner_st) begin
                    state_next   = IDLE;
                    st_done_next = 1'b1;
                end else begin
                    state_next = WAIT;
                    wcnt_next  = '0;
                end
            end
            WAIT: begin
                kill_next = kill_reg || flush_hit;
                if (wait_last) begin
                    state_next = IDLE;
                    if (owner_reg == req_id_t'(REQ_LD)) begin
                        ld_rvalid_next = 1'b1;
                        ld_rdata_next  = bus.mem_rdata;
                    end else if (!kill_reg && !flush_hit) begin
                        // A flushed fetch leaves the previous fetch data in place.
                        if_rvalid_next = 1'b1;
                        if_rdata_next  = bus.mem_rdata;
                    end
                end else begin
                    wcnt_next = wcnt_reg + 3'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            owner_reg     <= '0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wcnt_reg      <= '0;
            kill_reg      <= 1'b0;
            if_rvalid_reg <= 1'b0;
            ld_rvalid_reg <= 1'b0;
            st_done_reg   <= 1'b0;
            if_rdata_reg  <= '0;
            ld_rdata_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            wcnt_reg      <= wcnt_next;
            kill_reg      <= kill_next;
            if_rvalid_reg <= if_rvalid_next;
            ld_rvalid_reg <= ld_rvalid_next;
            st_done_reg   <= st_done_next;
            if_rdata_reg  <= if_rdata_next;
            ld_rdata_reg  <= ld_rdata_next;
        end
    end

    assign bus.if_gnt    = grant[REQ_IF];
    assign bus.ld_gnt    = grant[REQ_LD];
    assign bus.st_gnt    = grant[REQ_ST];
    assign bus.if_rvalid = if_rvalid_reg;
    assign bus.if_rdata  = if_rdata_reg;
    assign bus.ld_rvalid = ld_rvalid_reg;
    assign bus.ld_rdata  = ld_rdata_reg;
    assign bus.st_done   = st_done_reg;

    assign bus.mem_en    = in_access;
    assign bus.mem_we    = in_access && owner_st;
    assign bus.mem_addr  = in_access ? addr_reg : '0;
    assign bus.mem_wdata = (in_access && owner_st) ? wdata_reg : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RD_LAT=1 instance with response scoreboard,
// plus an RD_LAT=3 instance for latency and mid-read reset.
module tb_mem_port_arbiter;
    import cpu_mem_pkg::*;

    localparam int AW = 11;
    localparam int DW = 32;

    typedef struct {
        int          kind;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst1;
    logic rst3;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b3 ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .STARVE_MAX(4))
        u1 (.clk(clk), .reset(rst1), .bus(b1.slave));
    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .STARVE_MAX(4))
        u3 (.clk(clk), .reset(rst3), .bus(b3.slave));

    function automatic logic [31:0] pat(input logic [AW-1:0] a);
        return (a == 11'h010) ? 32'hDEADBEEF : {16'hC0DE, 5'b0, a};
    endfunction

    // SRAM models: unwritten words read back as pat(addr).
    logic [DW-1:0] wmem [0:2047];
    bit            wv   [0:2047];
    logic [DW-1:0] p1;
    logic [DW-1:0] p3 [0:2];

    always @(posedge clk) begin
        if (b1.mem_en && b1.mem_we) begin
            wmem[b1.mem_addr] <= b1.mem_wdata;
            wv[b1.mem_addr]   <= 1'b1;
        end
        p1 <= (b1.mem_en && !b1.mem_we)
              ? (wv[b1.mem_addr] ? wmem[b1.mem_addr] : pat(b1.mem_addr)) : '0;
        p3[0] <= (b3.mem_en && !b3.mem_we) ? pat(b3.mem_addr) : '0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign b1.mem_rdata = p1;
    assign b3.mem_rdata = p3[2];

    // Response monitor for instance 1: every pulse must match the queue head.
    logic        mon_pulse;
    logic [31:0] mon_data;
    exp_t        mon_e;
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            mon_pulse = (k == REQ_IF) ? b1.if_rvalid : (k == REQ_LD) ? b1.ld_rvalid : b1.st_done;
            mon_data  = (k == REQ_IF) ? b1.if_rdata : (k == REQ_LD) ? b1.ld_rdata : 32'h0;
            if (mon_pulse === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_resp kind=%0d cycle=%0d data=%h required=none", k, cyc, mon_data);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.kind !== k || mon_e.due !== cyc || (k != REQ_ST && mon_data !== mon_e.data)) begin
                        failures++;
                        $display("FAIL resp kind=%0d cycle=%0d data=%h required kind=%0d cycle=%0d data=%h",
                                 k, cyc, mon_data, mon_e.kind, mon_e.due, mon_e.data);
                    end else begin
                        $display("resp kind=%0d cycle=%0d data=%h ok", k, cyc, mon_data);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt1(output int g, output bit ok);
        ok = 1'b0;
        g  = -1;
        for (int i = 0; i < 24 && !ok; i++) begin
            @(negedge clk);
            if (b1.if_gnt || b1.ld_gnt || b1.st_gnt) begin
                g  = cyc;
                ok = 1'b1;
            end
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst1 = 1'b1; rst3 = 1'b1;
        b1.if_req = 1'b1; b1.if_addr = '0; b1.if_flush = 1'b0;
        b1.ld_req = 1'b1; b1.ld_addr = '0;
        b1.st_req = 1'b1; b1.st_addr = '0; b1.st_wdata = '0;
        b3.if_req = 1'b0; b3.if_addr = '0; b3.if_flush = 1'b0;
        b3.ld_req = 1'b0; b3.ld_addr = '0;
        b3.st_req = 1'b0; b3.st_addr = '0; b3.st_wdata = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({b1.if_gnt, b1.ld_gnt, b1.st_gnt} !== 3'b000) begin
            failures++; $display("FAIL reset_gnt got=%b required=000", {b1.if_gnt, b1.ld_gnt, b1.st_gnt});
        end
        checks++;
        if ({b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata} !== '0) begin
            failures++; $display("FAIL reset_mem got en=%b we=%b addr=%h wdata=%h required all 0",
                                 b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata);
        end
        checks++;
        if ({b1.if_rvalid, b1.ld_rvalid, b1.st_done, b1.if_rdata, b1.ld_rdata} !== '0) begin
            failures++; $display("FAIL reset_resp got=%b/%b/%b %h %h required all 0",
                                 b1.if_rvalid, b1.ld_rvalid, b1.st_done, b1.if_rdata, b1.ld_rdata);
        end
        checks++;
        if (u1.state_reg !== IDLE || u1.u_sel.starve_reg !== 3'd0) begin
            failures++; $display("FAIL reset_state got state=%0d starve=%0d required 0/0", u1.state_reg, u1.u_sel.starve_reg);
        end
        $display("reset checks done cycle=%0d", cyc);
        tick();
        b1.if_req = 1'b0; b1.ld_req = 1'b0; b1.st_req = 1'b0;
        tick();
        rst1 = 1'b0; rst3 = 1'b0;
    endtask

    task automatic test_single_load();
        int g; bit ok;
        tick();
        b1.ld_req = 1'b1; b1.ld_addr = 11'h010;
        wait_gnt1(g, ok);
        checks++;
        if (!ok || {b1.if_gnt, b1.ld_gnt, b1.st_gnt} !== 3'b010) begin
            failures++; $display("FAIL single_ld_gnt got=%b ok=%0d required=010", {b1.if_gnt, b1.ld_gnt, b1.st_gnt}, ok);
        end
        sb.push_back('{REQ_LD, 32'hDEADBEEF, g + 3});
        tick();
        b1.ld_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({b1.mem_en, b1.mem_we, b1.mem_addr} !== {1'b1, 1'b0, 11'h010}) begin
            failures++; $display("FAIL single_ld_access got en=%b we=%b addr=%h required 1/0/010", b1.mem_en, b1.mem_we, b1.mem_addr);
        end
        $display("single load granted cycle=%0d", g);
        wait_drain();
    endtask

    task automatic test_priority();
        int g; bit ok;
        tick();
        b1.st_req = 1'b1; b1.st_addr = 11'h005; b1.st_wdata = 32'h12345678;
        b1.ld_req = 1'b1; b1.ld_addr = 11'h020;
        b1.if_req = 1'b1; b1.if_addr = 11'h030;
        wait_gnt1(g, ok);
        checks++;
        if (!ok || {b1.if_gnt, b1.ld_gnt, b1.st_gnt} !== 3'b001) begin
            failures++; $display("FAIL prio_st_first got=%b required=001", {b1.if_gnt, b1.ld_gnt, b1.st_gnt});
        end
        sb.push_back('{REQ_ST, 32'h0, g + 2});
        tick();
        b1.st_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata} !== {1'b1, 1'b1, 11'h005, 32'h12345678}) begin
            failures++; $display("FAIL prio_st_access got en=%b we=%b addr=%h wdata=%h required 1/1/005/12345678",
                                 b1.mem_en, b1.mem_we, b1.mem_addr, b1.mem_wdata);
        end
        @(negedge clk);
        checks++;
        if ({b1.if_gnt, b1.ld_gnt, b1.st_gnt} !== 3'b010 || cyc != g + 2) begin
            failures++; $display("FAIL prio_ld_second got=%b cycle=%0d required=010 cycle=%0d",
                                 {b1.if_gnt, b1.ld_gnt, b1.st_gnt}, cyc, g + 2);
        end
        sb.push_back('{REQ_LD, pat(11'h020), g + 5});
        tick();
        b1.ld_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (b1.if_gnt !== 1'b0) begin
                failures++; $display("FAIL prio_if_early cycle=%0d got=%b required=0", cyc, b1.if_gnt);
            end
        end
        @(negedge clk);
        checks++;
        if (b1.if_gnt !== 1'b1) begin
            failures++; $display("FAIL prio_if_third cycle=%0d got=%b required=1", cyc, b1.if_gnt);
        end
        sb.push_back('{REQ_IF, pat(11'h030), g + 8});
        tick();
        b1.if_req = 1'b0;
        wait_drain();
    endtask

    task automatic test_starvation();
        int g; bit ok;
        tick();
        b1.if_req = 1'b1; b1.if_addr = 11'h040;
        b1.ld_req = 1'b1; b1.ld_addr = 11'h050;
        for (int n = 1; n <= 5; n++) begin
            wait_gnt1(g, ok);
            checks++;
            if (!ok || {b1.if_gnt, b1.ld_gnt, b1.st_gnt} !== ((n < 5) ? 3'b010 : 3'b100)
                || u1.u_sel.starve_reg !== 3'(n - 1)) begin
                failures++; $display("FAIL starve_arb%0d got gnt=%b cnt=%0d required gnt=%b cnt=%0d", n,
                                     {b1.if_gnt, b1.ld_gnt, b1.st_gnt}, u1.u_sel.starve_reg,
                                     (n < 5) ? 3'b010 : 3'b100, n - 1);
            end
            if (n < 5) sb.push_back('{REQ_LD, pat(11'h050), g + 3});
            else       sb.push_back('{REQ_IF, pat(11'h040), g + 3});
            tick();
        end
        b1.if_req = 1'b0; b1.ld_req = 1'b0;
        @(negedge clk);
        checks++;
        if (u1.u_sel.starve_reg !== 3'd0) begin
            failures++; $display("FAIL starve_clear got=%0d required=0", u1.u_sel.starve_reg);
        end
        wait_drain();
    endtask

    task automatic test_flush();
        int g; bit ok;
        tick();
        b1.if_req = 1'b1; b1.if_addr = 11'h100; b1.if_flush = 1'b1;
        @(negedge clk);
        checks++;
        if (b1.if_gnt !== 1'b0) begin
            failures++; $display("FAIL flush_idle_block got=%b required=0", b1.if_gnt);
        end
        tick();
        b1.if_flush = 1'b0;
        wait_gnt1(g, ok);
        checks++;
        if (!ok || b1.if_gnt !== 1'b1) begin
            failures++; $display("FAIL flush_if_gnt got=%b required=1", b1.if_gnt);
        end
        tick();
        b1.if_req = 1'b0;
        tick();
        b1.if_flush = 1'b1;
        tick();
        b1.if_flush = 1'b0;
        @(negedge clk);
        checks++;
        if (b1.if_rvalid !== 1'b0 || b1.if_rdata !== pat(11'h040)) begin
            failures++; $display("FAIL flush_kill got rvalid=%b rdata=%h required 0/%h", b1.if_rvalid, b1.if_rdata, pat(11'h040));
        end
        tick();
        b1.ld_req = 1'b1; b1.ld_addr = 11'h060;
        wait_gnt1(g, ok);
        checks++;
        if (!ok || b1.ld_gnt !== 1'b1) begin
            failures++; $display("FAIL flush_ld_gnt got=%b required=1", b1.ld_gnt);
        end
        sb.push_back('{REQ_LD, pat(11'h060), g + 3});
        tick();
        b1.ld_req = 1'b0;
        wait_drain();
        checks++;
        if (b1.if_rdata !== pat(11'h040)) begin
            failures++; $display("FAIL flush_rdata_hold got=%h required=%h", b1.if_rdata, pat(11'h040));
        end
    endtask

    task automatic test_back_to_back();
        int g; bit ok;
        tick();
        b1.st_req = 1'b1; b1.st_addr = 11'h000; b1.st_wdata = 32'hA0A00001;
        wait_gnt1(g, ok);
        checks++;
        if (!ok || b1.st_gnt !== 1'b1) begin
            failures++; $display("FAIL b2b_gnt0 got=%b required=1", b1.st_gnt);
        end
        sb.push_back('{REQ_ST, 32'h0, g + 2});
        tick();
        b1.st_addr = 11'h001; b1.st_wdata = 32'hB0B00002;
        @(negedge clk);
        checks++;
        if ({b1.mem_en, b1.mem_addr, b1.mem_wdata} !== {1'b1, 11'h000, 32'hA0A00001}) begin
            failures++; $display("FAIL b2b_access0 got en=%b addr=%h wdata=%h required 1/000/a0a00001", b1.mem_en, b1.mem_addr, b1.mem_wdata);
        end
        @(negedge clk);
        checks++;
        if (b1.mem_en !== 1'b0 || b1.st_gnt !== 1'b1) begin
            failures++; $display("FAIL b2b_gnt1 got en=%b gnt=%b required 0/1", b1.mem_en, b1.st_gnt);
        end
        sb.push_back('{REQ_ST, 32'h0, g + 4});
        tick();
        b1.st_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({b1.mem_en, b1.mem_addr, b1.mem_wdata} !== {1'b1, 11'h001, 32'hB0B00002}) begin
            failures++; $display("FAIL b2b_access1 got en=%b addr=%h wdata=%h required 1/001/b0b00002", b1.mem_en, b1.mem_addr, b1.mem_wdata);
        end
        @(negedge clk);
        checks++;
        if (b1.mem_en !== 1'b0) begin
            failures++; $display("FAIL b2b_idle got en=%b required=0", b1.mem_en);
        end
        tick();
        b1.ld_req = 1'b1; b1.ld_addr = 11'h001;
        wait_gnt1(g, ok);
        sb.push_back('{REQ_LD, 32'hB0B00002, g + 3});
        tick();
        b1.ld_req = 1'b0;
        wait_drain();
    endtask

    task automatic test_reset_mid_read();
        int g; int seen;
        for (int t = 0; t < 3; t++) begin
            tick();
            b3.ld_req = 1'b1; b3.ld_addr = 11'h071 + 11'(t);
            @(negedge clk);
            g = cyc;
            checks++;
            if (b3.ld_gnt !== 1'b1) begin
                failures++; $display("FAIL lat3_gnt%0d got=%b required=1", t, b3.ld_gnt);
            end
            tick();
            b3.ld_req = 1'b0;
            if (t == 1) begin
                tick();
                tick();
                rst3 = 1'b1;
                #1;
                checks++;
                if ({b3.ld_rvalid, b3.ld_rdata, b3.if_rvalid, b3.if_rdata, b3.st_done,
                     b3.mem_en, b3.mem_we, b3.mem_addr, b3.mem_wdata,
                     b3.if_gnt, b3.ld_gnt, b3.st_gnt} !== '0) begin
                    failures++; $display("FAIL lat3_async_reset got ld_rvalid=%b ld_rdata=%h required all 0",
                                         b3.ld_rvalid, b3.ld_rdata);
                end
                tick();
                rst3 = 1'b0;
            end
            seen = -1;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (b3.ld_rvalid === 1'b1 && seen < 0) seen = cyc;
            end
            checks++;
            if (t == 1) begin
                if (seen != -1) begin
                    failures++; $display("FAIL lat3_no_resp got rvalid at cycle=%0d required none", seen);
                end
            end else if (seen != g + 5 || b3.ld_rdata !== pat(11'h071 + 11'(t))) begin
                failures++; $display("FAIL lat3_resp%0d got cycle=%0d data=%h required cycle=%0d data=%h",
                                     t, seen, b3.ld_rdata, g + 5, pat(11'h071 + 11'(t)));
            end
            $display("lat3 transaction %0d gnt cycle=%0d rvalid cycle=%0d", t, g, seen);
        end
    endtask

    task automatic test_scoreboard_empty();
        wait_drain();
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL sb_empty got=%0d outstanding required=0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_priority();
        test_starvation();
        test_flush();
        test_back_to_back();
        test_reset_mid_read();
        test_scoreboard_empty();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port synchronous SRAM between the pipelined CPU's three memory requesters: instruction fetch (read), load (read) and store (write). Accepts one request at a time through a req/gnt handshake and issues exactly one memory access. Returns read data or a write-complete pulse to the winning requester. Sits between the CPU memory interface and the shared instruction/data memory.

Parameters:
ADDR_W, 11, memory address width
DATA_W, 32, memory data width
RD_LAT, 1, SRAM read latency in cycles from mem_en to valid mem_rdata (legal 1..4)
STARVE_MAX, 4, consecutive denied IDLE cycles after which fetch is promoted to top priority

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch read request
if_addr  in  ADDR_W  fetch address
if_flush  in  1  branch taken; discard any outstanding fetch response
if_gnt  out  1  fetch accepted this cycle
if_rvalid  out  1  fetch data valid, one-cycle pulse
if_rdata  out  DATA_W  fetch data
ld_req  in  1  load read request
ld_addr  in  ADDR_W  load address
ld_gnt  out  1  load accepted
ld_rvalid  out  1  load data valid pulse
ld_rdata  out  DATA_W  load data
st_req  in  1  store request
st_addr  in  ADDR_W  store address
st_wdata  in  DATA_W  store data
st_gnt  out  1  store accepted
st_done  out  1  store written, one-cycle pulse
mem_en  out  1  SRAM access enable
mem_we  out  1  SRAM write enable
mem_addr  out  ADDR_W  SRAM address
mem_wdata  out  DATA_W  SRAM write data
mem_rdata  in  DATA_W  SRAM read data

Behaviour:
- Reset: state IDLE, starvation counter 0, wait counter 0. Every output is 0: gnt, rvalid, rdata, st_done, mem_en, mem_we, mem_addr, mem_wdata. Reset mid-transaction drops the access; no response is ever pulsed for it.
- FSM states: IDLE, ACCESS, WAIT.
- IDLE: x_gnt is combinational from the registered state and the requests. At most one gnt is high. Address and data are sampled on the gnt edge. The requester drops req the next cycle unless it has a new request. Transition: IDLE -> ACCESS.
- Priority: st > ld > if. When the starvation counter equals STARVE_MAX and if_req=1, fetch wins outright.
- Starvation counter: increments in each IDLE cycle where if_req=1 and if_gnt=0. It saturates at STARVE_MAX and clears on if_gnt.
- ACCESS (exactly 1 cycle): mem_en=1 and mem_addr is registered. For a store, mem_we=1 and mem_wdata=st_wdata. A store goes to IDLE and pulses st_done in the next cycle. A read goes to WAIT.
- WAIT: counts RD_LAT cycles and captures mem_rdata on the last one. In the next cycle it pulses x_rvalid with x_rdata and returns to IDLE.
- rdata holds its value until the next capture.
- Latency from the gnt cycle (cycle 0):
  - read rvalid in cycle RD_LAT+2
  - store st_done in cycle 2
- IDLE may grant a new request in the same cycle a response pulses, so back-to-back throughput is one access per RD_LAT+2 cycles for reads and 2 cycles for stores.
- mem_en, mem_we, mem_addr and mem_wdata are 0 outside ACCESS.
- if_flush:
  - In any cycle while a fetch read is in ACCESS or WAIT, it sets a kill flag. if_rvalid is then suppressed for that transaction, and if_rdata is not updated.
  - In IDLE it blocks if_gnt for that cycle.
  - It never affects ld or st transactions.
- Requests arriving during ACCESS/WAIT are ignored until IDLE; requesters must hold req.

Decomposition:
- Package cpu_mem_pkg:
  - state encoding (IDLE, ACCESS, WAIT)
  - requester ID constants (REQ_IF, REQ_LD, REQ_ST)
  - default ADDR_W/DATA_W
- Sub-module mem_arb_select: combinational priority select, plus the registered starvation counter. Outputs a one-hot grant vector.

Test Plan:
- Single load, RD_LAT=1: ld_req with ld_addr=0x010 while the memory returns 0xDEADBEEF -> ld_gnt in cycle 0; mem_en=1, mem_addr=0x010 in cycle 1; ld_rvalid=1, ld_rdata=0xDEADBEEF in cycle 3; st_done and if_rvalid stay 0.
- Simultaneous st_req(addr 0x005, data 0x12345678), ld_req and if_req -> st_gnt first, with mem_we=1 and mem_wdata=0x12345678 in cycle 1 and st_done in cycle 2. ld_gnt follows in cycle 2, then if_gnt only after the load returns.
- Starvation, STARVE_MAX=4: if_req held while ld_req is re-asserted continuously -> if_gnt asserted on the 5th IDLE arbitration even with ld_req=1, and the counter reads 0 afterwards.
- Flush: fetch granted at addr 0x100, if_flush pulsed in the WAIT cycle -> no if_rvalid, if_rdata unchanged. A following load completes normally.
- Reset mid-read, RD_LAT=3: assert reset during WAIT -> all outputs 0 immediately (async), no rvalid after release; a new ld_req completes in cycle RD_LAT+2=5.
- Back-to-back stores to 0x000 and 0x001 -> mem_en pulses in cycles 1 and 3, st_done pulses in cycles 2 and 4.
